// File: rtl/song_reader_if.sv
// song_reader_if
// Bundles the song reader's control and ROM signals so the player, ROM and
// note player can be wired with a single connection.
//   play             : level, 1 = run song, 0 = pause
//   song             : selected song number
//   rom_addr         : {song, note index} presented to a synchronous ROM
//   rom_data         : {note[11:6], duration[5:0]}, one cycle after rom_addr
//   note_to_load     : note code handed to the note player
//   duration_to_load : note length in beats
//   load_new_note    : one-cycle strobe, note/duration valid with it
//   note_done        : one-cycle strobe from the note player
//   song_done        : one-cycle strobe at the end of a song
// slave modport is the song reader's view, master is the environment's view.
interface song_reader_if #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
);
  logic                           play;
  logic [SONG_BITS-1:0]           song;
  logic [SONG_BITS+NOTE_BITS-1:0] rom_addr;
  logic [11:0]                    rom_data;
  logic [5:0]                     note_to_load;
  logic [5:0]                     duration_to_load;
  logic                           load_new_note;
  logic                           note_done;
  logic                           song_done;

  modport slave (
    input  play, song, rom_data, note_done,
    output rom_addr, note_to_load, duration_to_load, load_new_note, song_done
  );

  modport master (
    output play, song, rom_data, note_done,
    input  rom_addr, note_to_load, duration_to_load, load_new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// song_reader
// Walks through the notes of the selected song in a synchronous ROM and hands
// each note to a note player, waiting for the player to finish before moving
// on. A zero duration marks the end of a song; otherwise the song ends after
// its last (2^NOTE_BITS-1) note.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : song_reader_if.slave (play, song, rom_addr, rom_data,
//           note_to_load, duration_to_load, load_new_note, note_done,
//           song_done)
// Build option:
//   SONG_LOOP_EN defined   -> after the end of a song it restarts at note 0
//   SONG_LOOP_EN undefined -> it stops until play drops or the song changes
module song_reader #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic          clk,
  input  logic          reset,
  song_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_END,
    S_STOPPED
  } state_t;

  localparam logic [NOTE_BITS-1:0] LAST_NOTE = '1;

  state_t                         r_state;
  logic [SONG_BITS-1:0]           r_song_latched;
  logic [NOTE_BITS-1:0]           r_note_index;
  logic [SONG_BITS+NOTE_BITS-1:0] r_rom_addr;
  logic [5:0]                     r_note_to_load;
  logic [5:0]                     r_duration_to_load;
  logic                           r_load_new_note;
  logic                           r_song_done;

  logic [NOTE_BITS-1:0]           w_next_index;

  assign w_next_index = r_note_index + NOTE_BITS'(1);

  // Outputs are registered alongside the state so they match the state the
  // FSM is entering (load in ISSUE, song_done in END).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= S_IDLE;
      r_song_latched     <= '0;
      r_note_index       <= '0;
      r_rom_addr         <= '0;
      r_note_to_load     <= '0;
      r_duration_to_load <= '0;
      r_load_new_note    <= 1'b0;
      r_song_done        <= 1'b0;
    end else begin
      r_load_new_note <= 1'b0;
      r_song_done     <= 1'b0;
      if (bus.song != r_song_latched) begin
        // A new song restarts from its first note, overriding everything.
        r_song_latched <= bus.song;
        r_note_index   <= '0;
        r_state        <= S_IDLE;
      end else if (!bus.play && r_state != S_STOPPED) begin
        // Pause keeps the note index, so resuming replays the current note.
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            // play is known high here; the pause branch caught play low.
            r_state    <= S_FETCH;
            r_rom_addr <= {r_song_latched, r_note_index};
          end
          S_FETCH: begin
            // The ROM word for rom_addr arrives during DECODE.
            r_state <= S_DECODE;
          end
          S_DECODE: begin
            if (bus.rom_data[5:0] == 6'd0) begin
              r_state     <= S_END;
              r_song_done <= 1'b1;
            end else begin
              r_note_to_load     <= bus.rom_data[11:6];
              r_duration_to_load <= bus.rom_data[5:0];
              r_load_new_note    <= 1'b1;
              r_state            <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (bus.note_done) begin
              if (r_note_index == LAST_NOTE) begin
                r_state     <= S_END;
                r_song_done <= 1'b1;
              end else begin
                r_note_index <= w_next_index;
                r_rom_addr   <= {r_song_latched, w_next_index};
                r_state      <= S_FETCH;
              end
            end
          end
          S_END: begin
`ifdef SONG_LOOP_EN
            r_note_index <= '0;
            r_rom_addr   <= {r_song_latched, {NOTE_BITS{1'b0}}};
            r_state      <= S_FETCH;
`else
            r_state <= S_STOPPED;
`endif
          end
          S_STOPPED: begin
            // Leaves only when play drops; a song change is handled above.
            if (!bus.play) begin
              r_note_index <= '0;
              r_state      <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr         = r_rom_addr;
  assign bus.note_to_load     = r_note_to_load;
  assign bus.duration_to_load = r_duration_to_load;
  assign bus.load_new_note    = r_load_new_note;
  assign bus.song_done        = r_song_done;

endmodule
